// File: rtl/seg_scan_display.sv
// seg_scan_display: N-digit multiplexed 7-segment scanner with internal refresh prescaler,
// per-digit dp/blank/blink. Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.

module seg_digit_enc (
   input  logic [3:0] nib,
   input  logic       dp,
   input  logic       dark,
   input  logic       sup,
   output logic [7:0] pat
);
   logic [6:0] glyph;

   always_comb begin
      glyph = 7'h7F;
      case (nib)
         4'h0: glyph = 7'h40;
         4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;
         4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;
         4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;
         4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;
         4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;
         4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;
         4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;
         4'hF: glyph = 7'h0E;
         default: glyph = 7'h7F;
      endcase
   end

   // dark wins over everything, a suppressed zero still carries its dp
   always_comb begin
      if (dark)     pat = 8'hFF;
      else if (sup) pat = {~dp, 7'h7F};
      else          pat = {~dp, glyph};
   end
endmodule

module seg_scan_display #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp_mask,
   input  logic [NUM_DIGITS-1:0]     blank_mask,
   input  logic [NUM_DIGITS-1:0]     blink_mask,
   output logic [7:0]                seg,
   output logic [NUM_DIGITS-1:0]     an
);
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
   localparam int BW = (BLINK_DIV   > 1) ? $clog2(BLINK_DIV)   : 1;

   logic [PW-1:0]                pre;
   logic [IW-1:0]                idx;
   logic [BW-1:0]                bcnt;
   logic                         blink_on;
   logic                         tick;
   logic [NUM_DIGITS-1:0]        sup;
   logic [NUM_DIGITS-1:0][7:0]   pat;

   assign tick = (pre == PW'(REFRESH_DIV - 1));

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
      seg_digit_enc u_enc (
         .nib  (digits[4*g +: 4]),
         .dp   (dp_mask[g]),
         .dark (blank_mask[g] | (blink_mask[g] & ~blink_on)),
         .sup  (sup[g]),
         .pat  (pat[g])
      );
   end

`ifdef LEADING_ZERO_BLANK_EN
   // walk down from the top digit; suppression stops at the first nonzero digit
   logic lz_run;
   always_comb begin
      lz_run = 1'b1;
      sup    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         lz_run = lz_run & (digits[4*i +: 4] == 4'h0);
         sup[i] = lz_run & (i != 0);
      end
   end
`else
   assign sup = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre      <= '0;
         idx      <= '0;
         bcnt     <= '0;
         blink_on <= 1'b1;
         an       <= '1;
         seg      <= 8'hFF;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick)
            idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;

         // idle mask pins the phase so blinking always opens with a visible half
         if (blink_mask == '0) begin
            bcnt     <= '0;
            blink_on <= 1'b1;
         end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt     <= '0;
            blink_on <= ~blink_on;
         end else begin
            bcnt <= bcnt + 1'b1;
         end

         if (!enable) begin
            an  <= '1;
            seg <= 8'hFF;
         end else if (tick) begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= pat[idx];
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: a cycle model pushes expected {an,seg} per edge,
// the monitor pops and compares against the DUT.

module tb_seg_scan_display;
   localparam int N = 4;
   localparam int R = 4;
   localparam int B = 32;
   localparam logic [7:0] GLY [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b1;
   logic [15:0]   digits = 16'h0;
   logic [3:0]    dp_mask = 4'h0, blank_mask = 4'h0, blink_mask = 4'h0;
   logic [7:0]    seg;
   logic [3:0]    an;

   int n_run = 0, n_fail = 0;
   logic [11:0] sb_q[$];

   int m_pre, m_idx, m_bcnt;
   bit m_bon;
   logic [3:0] e_an;
   logic [7:0] e_seg;

   seg_scan_display #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .digits(digits), .dp_mask(dp_mask),
      .blank_mask(blank_mask), .blink_mask(blink_mask), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] exp_pat(input int i, input bit bon);
      logic [3:0] d;
      bit s;
      d = digits[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      s = (i >= 1) && ((digits >> (4*i)) == 16'h0);
`else
      s = 1'b0;
`endif
      if (blank_mask[i] || (blink_mask[i] && !bon)) return 8'hFF;
      if (s) return {~dp_mask[i], 7'h7F};
      return {~dp_mask[i], GLY[d][6:0]};
   endfunction

   task automatic m_reset();
      m_pre = 0; m_idx = 0; m_bcnt = 0; m_bon = 1'b1;
      e_an = 4'hF; e_seg = 8'hFF;
   endtask

   // advance the model over the edge just taken, using the inputs held across it
   task automatic m_step();
      bit tk;
      if (!rst_n) m_reset();
      else begin
         tk = (m_pre == R - 1);
         if (!enable) begin
            e_an = 4'hF; e_seg = 8'hFF;
         end else if (tk) begin
            e_an = ~(4'b1 << m_idx); e_seg = exp_pat(m_idx, m_bon);
         end
         m_pre = tk ? 0 : m_pre + 1;
         if (tk) m_idx = (m_idx + 1) % N;
         if (blink_mask == 4'h0) begin
            m_bcnt = 0; m_bon = 1'b1;
         end else if (m_bcnt == B - 1) begin
            m_bcnt = 0; m_bon = !m_bon;
         end else m_bcnt++;
      end
      sb_q.push_back({e_an, e_seg});
   endtask

   task automatic run(input int n);
      logic [11:0] e;
      repeat (n) begin
         @(posedge clk); #1;
         m_step();
         e = sb_q.pop_front();
         chk("scan", {4'h0, an, seg}, {4'h0, e});
      end
   endtask

   task automatic first_load();
      int cyc;
      cyc = 0;
      while (an == 4'hF && cyc < 20) begin
         run(1);
         cyc++;
      end
      chk("first_load_lat", 16'(cyc), 16'd4);
      chk("first_load_an", {12'h0, an}, 16'h000E);
   endtask

   initial begin
      m_reset();
      digits = 16'h1230;
      run(3);
      chk("rst_an", {12'h0, an}, 16'h000F);
      chk("rst_seg", {8'h0, seg}, 16'h00FF);
      #3 rst_n = 1'b1;
      first_load();
      chk("first_load_seg", {8'h0, seg}, 16'h00C0);
      run(20);

      digits = 16'hABCD; dp_mask = 4'b0100;
      run(20);

      digits = 16'h5555; dp_mask = 4'h0; blink_mask = 4'b0011;
      run(140);
      blink_mask = 4'h0;
      run(12);

      run(2);
      enable = 1'b0;
      run(3);
      enable = 1'b1;
      run(10);
      blank_mask = 4'b1000;
      run(12);
      blank_mask = 4'h0;

      digits = 16'h1230;
      run(1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_an", {12'h0, an}, 16'h000F);
      chk("async_rst_seg", {8'h0, seg}, 16'h00FF);
      m_reset();
      #2 rst_n = 1'b1;
      first_load();
      chk("rerst_seg", {8'h0, seg}, 16'h00C0);
      run(8);

      digits = 16'h0050;
      run(20);
      dp_mask = 4'b1000;
      run(12);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
